phase_cal_array: RTL and testbench
==================================

# phase_cal_array

Parametrised multi-channel phase/amplitude calibration and monopulse combiner. It multiplies each real ADC channel by a per-channel complex calibration coefficient, then forms the complex sum beam and difference beam across channels. It sits between the ADC capture framing (sop/eop/valid) and the range FFT. Coefficients, channel mask and framing are frame-coherent: they are latched only at start of packet, so a frame is never processed with mixed coefficients.

## Interface
Parameters:
- NCH, 2: channel count; even, 2..8. Channels 0..NCH/2-1 form half A and the rest form half B.
- DW, 16: signed ADC sample width.
- CW, 16: signed width of each coefficient component (I and Q).
- CFRAC, 14: fractional bits of the coefficient; unity = 2^CFRAC.
- OW, 16: signed width of each output component.

Ports:
- sys_clk  in  1  single clock for the block.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  sample qualifier, shared by all channels.
- in_sop  in  1  first sample of frame; ignored unless in_valid.
- in_eop  in  1  last sample of frame; ignored unless in_valid.
- in_data  in  NCH*DW  channel k at [k*DW +: DW], signed.
- coef  in  NCH*2*CW  channel k {Q,I} at [k*2*CW +: 2*CW], signed.
- ch_mask  in  NCH  1 = channel contributes; 0 = channel treated as zero.
- ovf_clr  in  1  clears ovf_sticky.
- sum_valid, sum_sop, sum_eop  out  1  framing for sum_data.
- sum_data  out  2*OW  {Q,I} of the sum beam.
- diff_valid, diff_sop, diff_eop  out  1  framing for diff_data; identical timing to the sum outputs.
- diff_data  out  2*OW  {Q,I} of the difference beam (A − B).
- ovf_sticky  out  1  set when any output saturates.

## Operation
- **Shadow registers.** When in_valid & in_sop, coef and ch_mask are captured into shadow registers. That sample and every later sample use the shadow until the next qualified sop.
- **Shadow reset value.** Every channel I = 2^CFRAC, Q = 0; mask all ones.
- **Ignored inputs.** coef and ch_mask changes at any other time are ignored.
- **Product.** Per channel: pI = x·cI, pQ = x·cQ, full width DW+CW.
- **Rounding.** Add 2^(CFRAC-1), then arithmetic shift right by CFRAC (round half up). A masked channel contributes 0.
- **Combine.**
  - sum = Σ over all channels.
  - diff = Σ over half A − Σ over half B.
  - Accumulate at width DW+CW−CFRAC+clog2(NCH)+1, so there is no internal overflow.
- **Saturation.**
  - Each output component is clipped to [−2^(OW−1), 2^(OW−1)−1].
  - Any clip on a valid sample sets ovf_sticky.
  - ovf_sticky clears only on ovf_clr. If a new clip and ovf_clr occur in the same cycle, set wins.
- **Non-valid cycles.** The pipeline advances every cycle. On cycles where the delayed valid is 0, sum_data and diff_data hold their previous values.
- **Framing.** sop, eop and valid pass through unchanged; sop and eop are ANDed with valid. Single-sample frames (sop and eop together) are legal.

## Timing
- Fixed latency of 5 cycles, from the input sample edge to output valid. Stages:
  - S1: input register plus shadow capture.
  - S2: multiply.
  - S3: round and mask.
  - S4: adder tree.
  - S5: saturate and output register.
- Throughput: one sample per cycle. There is no backpressure.
- Reset values:
  - All outputs are 0 (valid, sop, eop, data, ovf_sticky).
  - Shadow registers go to unity coefficient and all-ones mask.
- Reset asserted mid-frame: all in-flight samples are discarded and no output valid follows. The first frame after reset must begin with sop. Samples before that sop use the unity shadow.

## Test plan
1. **Unity default.** NCH=2, CFRAC=14, no sop after reset. ch0=1000, ch1=200, valid for 1 cycle → 5 cycles later sum = {Q 0, I 1200}, diff = {Q 0, I 800}, sum_valid=1 for 1 cycle.
2. **Frame-coherent coefficients.**
   - Change ch0 coef to I=0, Q=16384 mid-frame → no change in output.
   - At the next sop with ch0=1000, ch1=0 → sum = {Q 1000, I 0}.
   - A later frame with coef unity → I=1000.
3. **Rounding and mask.** ch0 coef I=8192, mask=01. x0=3 → sum I=2; x0=−3 → sum I=−1; ch1=5000 has no effect.
4. **Saturation.**
   - ch0=ch1=32767, unity coef → sum I=32767, diff I=0, ovf_sticky=1.
   - Pulse ovf_clr → 0.
   - ovf_clr in the same cycle as a new clip → stays 1.
5. **Framing.** 8-sample frame with valid gaps at samples 3 and 6 → out sop/eop/valid equal to the input pattern shifted exactly 5 cycles; data holds during gaps.
6. **Reset.** Assert rst_n low at frame sample 4 for 2 cycles → no output valid for in-flight samples; outputs read 0; the next frame after sop processes correctly with unity shadow restored.

Source files
------------

// File: rtl/phase_cal_array.sv
// Per-channel complex calibration of real ADC samples followed by
// monopulse sum (all channels) and difference (half A - half B) beams.
module phase_cal_array #(
  parameter int NCH   = 2,
  parameter int DW    = 16,
  parameter int CW    = 16,
  parameter int CFRAC = 14,
  parameter int OW    = 16
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  in_sop,
  input  logic                  in_eop,
  input  logic [NCH*DW-1:0]     in_data,
  input  logic [NCH*2*CW-1:0]   coef,
  input  logic [NCH-1:0]        ch_mask,
  input  logic                  ovf_clr,
  output logic                  sum_valid,
  output logic                  sum_sop,
  output logic                  sum_eop,
  output logic [2*OW-1:0]       sum_data,
  output logic                  diff_valid,
  output logic                  diff_sop,
  output logic                  diff_eop,
  output logic [2*OW-1:0]       diff_data,
  output logic                  ovf_sticky
);

  localparam int PW = DW + CW;
  localparam int RW = PW - CFRAC + 1;
  localparam int LG = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int AW = RW + LG;
  localparam int HA = NCH / 2;
  localparam int KW = 2 * CW;

  localparam logic signed [PW:0] RHALF =
    {{(PW + 1 - CFRAC){1'b0}}, 1'b1, {(CFRAC - 1){1'b0}}};

  localparam logic signed [AW-1:0] SMAX =
    {{(AW - OW + 1){1'b0}}, {(OW - 1){1'b1}}};
  localparam logic signed [AW-1:0] SMIN =
    {{(AW - OW + 1){1'b1}}, {(OW - 1){1'b0}}};

  function automatic logic [NCH*KW-1:0] unity_coef();
    logic [NCH*KW-1:0] v;
    v = '0;
    for (int k = 0; k < NCH; k++) begin
      v[k*KW + CFRAC] = 1'b1;
    end
    return v;
  endfunction

  localparam logic [NCH*KW-1:0] COEF_RST = unity_coef();

  // {clip, value}: clamp an accumulator to the output range
  function automatic logic [OW:0] sat(
    input logic signed [AW-1:0] v
  );
    if (v > SMAX) begin
      return {1'b1, SMAX[OW-1:0]};
    end else if (v < SMIN) begin
      return {1'b1, SMIN[OW-1:0]};
    end else begin
      return {1'b0, OW'(v)};
    end
  endfunction

  logic                   s1_valid_q, s1_valid_d;
  logic                   s1_sop_q, s1_sop_d;
  logic                   s1_eop_q, s1_eop_d;
  logic [NCH*DW-1:0]      s1_data_q, s1_data_d;
  logic [NCH*KW-1:0]      coef_sh_q, coef_sh_d;
  logic [NCH-1:0]         mask_sh_q, mask_sh_d;

  logic                   s2_valid_q, s2_valid_d;
  logic                   s2_sop_q, s2_sop_d;
  logic                   s2_eop_q, s2_eop_d;
  logic [NCH-1:0]         s2_mask_q, s2_mask_d;
  logic signed [PW-1:0]   prod_i_q [NCH];
  logic signed [PW-1:0]   prod_i_d [NCH];
  logic signed [PW-1:0]   prod_q_q [NCH];
  logic signed [PW-1:0]   prod_q_d [NCH];

  logic                   s3_valid_q, s3_valid_d;
  logic                   s3_sop_q, s3_sop_d;
  logic                   s3_eop_q, s3_eop_d;
  logic signed [RW-1:0]   rnd_i_q [NCH];
  logic signed [RW-1:0]   rnd_i_d [NCH];
  logic signed [RW-1:0]   rnd_q_q [NCH];
  logic signed [RW-1:0]   rnd_q_d [NCH];

  logic                   s4_valid_q, s4_valid_d;
  logic                   s4_sop_q, s4_sop_d;
  logic                   s4_eop_q, s4_eop_d;
  logic signed [AW-1:0]   acc_sum_i_q, acc_sum_i_d;
  logic signed [AW-1:0]   acc_sum_q_q, acc_sum_q_d;
  logic signed [AW-1:0]   acc_dif_i_q, acc_dif_i_d;
  logic signed [AW-1:0]   acc_dif_q_q, acc_dif_q_d;

  logic                   out_valid_q, out_valid_d;
  logic                   out_sop_q, out_sop_d;
  logic                   out_eop_q, out_eop_d;
  logic [2*OW-1:0]        out_sum_q, out_sum_d;
  logic [2*OW-1:0]        out_dif_q, out_dif_d;
  logic                   ovf_q, ovf_d;

  // S1: register input; shadow loads on qualified sop so that
  // the sop sample itself already sees the new coefficients
  always_comb begin
    s1_valid_d = in_valid;
    s1_sop_d   = in_valid & in_sop;
    s1_eop_d   = in_valid & in_eop;
    s1_data_d  = in_data;
    coef_sh_d  = coef_sh_q;
    mask_sh_d  = mask_sh_q;
    if (in_valid && in_sop) begin
      coef_sh_d = coef;
      mask_sh_d = ch_mask;
    end
  end

  // S2: full-width products
  always_comb begin
    logic signed [DW-1:0] x;
    logic signed [CW-1:0] ci;
    logic signed [CW-1:0] cq;
    s2_valid_d = s1_valid_q;
    s2_sop_d   = s1_sop_q;
    s2_eop_d   = s1_eop_q;
    s2_mask_d  = mask_sh_q;
    for (int k = 0; k < NCH; k++) begin
      x  = s1_data_q[k*DW +: DW];
      ci = coef_sh_q[k*KW +: CW];
      cq = coef_sh_q[k*KW + CW +: CW];
      prod_i_d[k] = PW'(x) * PW'(ci);
      prod_q_d[k] = PW'(x) * PW'(cq);
    end
  end

  // S3: round half up, drop masked channels
  always_comb begin
    s3_valid_d = s2_valid_q;
    s3_sop_d   = s2_sop_q;
    s3_eop_d   = s2_eop_q;
    for (int k = 0; k < NCH; k++) begin
      rnd_i_d[k] = '0;
      rnd_q_d[k] = '0;
      if (s2_mask_q[k]) begin
        rnd_i_d[k] = RW'(((PW+1)'(prod_i_q[k]) + RHALF) >>> CFRAC);
        rnd_q_d[k] = RW'(((PW+1)'(prod_q_q[k]) + RHALF) >>> CFRAC);
      end
    end
  end

  // S4: sum and difference trees
  always_comb begin
    s4_valid_d  = s3_valid_q;
    s4_sop_d    = s3_sop_q;
    s4_eop_d    = s3_eop_q;
    acc_sum_i_d = '0;
    acc_sum_q_d = '0;
    acc_dif_i_d = '0;
    acc_dif_q_d = '0;
    for (int k = 0; k < NCH; k++) begin
      acc_sum_i_d = acc_sum_i_d + AW'(rnd_i_q[k]);
      acc_sum_q_d = acc_sum_q_d + AW'(rnd_q_q[k]);
      if (k < HA) begin
        acc_dif_i_d = acc_dif_i_d + AW'(rnd_i_q[k]);
        acc_dif_q_d = acc_dif_q_d + AW'(rnd_q_q[k]);
      end else begin
        acc_dif_i_d = acc_dif_i_d - AW'(rnd_i_q[k]);
        acc_dif_q_d = acc_dif_q_d - AW'(rnd_q_q[k]);
      end
    end
  end

  // S5: saturate; data holds across gaps
  always_comb begin
    logic [OW:0] s_i;
    logic [OW:0] s_q;
    logic [OW:0] d_i;
    logic [OW:0] d_q;
    logic        clip;
    s_i  = sat(acc_sum_i_q);
    s_q  = sat(acc_sum_q_q);
    d_i  = sat(acc_dif_i_q);
    d_q  = sat(acc_dif_q_q);
    clip = s4_valid_q & (s_i[OW] | s_q[OW] | d_i[OW] | d_q[OW]);
    out_valid_d = s4_valid_q;
    out_sop_d   = s4_sop_q;
    out_eop_d   = s4_eop_q;
    out_sum_d   = out_sum_q;
    out_dif_d   = out_dif_q;
    if (s4_valid_q) begin
      out_sum_d = {s_q[OW-1:0], s_i[OW-1:0]};
      out_dif_d = {d_q[OW-1:0], d_i[OW-1:0]};
    end
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (clip) ovf_d = 1'b1;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_sop_q    <= 1'b0;
      s1_eop_q    <= 1'b0;
      s1_data_q   <= '0;
      coef_sh_q   <= COEF_RST;
      mask_sh_q   <= '1;
      s2_valid_q  <= 1'b0;
      s2_sop_q    <= 1'b0;
      s2_eop_q    <= 1'b0;
      s2_mask_q   <= '0;
      prod_i_q    <= '{default: '0};
      prod_q_q    <= '{default: '0};
      s3_valid_q  <= 1'b0;
      s3_sop_q    <= 1'b0;
      s3_eop_q    <= 1'b0;
      rnd_i_q     <= '{default: '0};
      rnd_q_q     <= '{default: '0};
      s4_valid_q  <= 1'b0;
      s4_sop_q    <= 1'b0;
      s4_eop_q    <= 1'b0;
      acc_sum_i_q <= '0;
      acc_sum_q_q <= '0;
      acc_dif_i_q <= '0;
      acc_dif_q_q <= '0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_sum_q   <= '0;
      out_dif_q   <= '0;
      ovf_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sop_q    <= s1_sop_d;
      s1_eop_q    <= s1_eop_d;
      s1_data_q   <= s1_data_d;
      coef_sh_q   <= coef_sh_d;
      mask_sh_q   <= mask_sh_d;
      s2_valid_q  <= s2_valid_d;
      s2_sop_q    <= s2_sop_d;
      s2_eop_q    <= s2_eop_d;
      s2_mask_q   <= s2_mask_d;
      prod_i_q    <= prod_i_d;
      prod_q_q    <= prod_q_d;
      s3_valid_q  <= s3_valid_d;
      s3_sop_q    <= s3_sop_d;
      s3_eop_q    <= s3_eop_d;
      rnd_i_q     <= rnd_i_d;
      rnd_q_q     <= rnd_q_d;
      s4_valid_q  <= s4_valid_d;
      s4_sop_q    <= s4_sop_d;
      s4_eop_q    <= s4_eop_d;
      acc_sum_i_q <= acc_sum_i_d;
      acc_sum_q_q <= acc_sum_q_d;
      acc_dif_i_q <= acc_dif_i_d;
      acc_dif_q_q <= acc_dif_q_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_sum_q   <= out_sum_d;
      out_dif_q   <= out_dif_d;
      ovf_q       <= ovf_d;
    end
  end

  assign sum_valid  = out_valid_q;
  assign sum_sop    = out_sop_q;
  assign sum_eop    = out_eop_q;
  assign sum_data   = out_sum_q;
  assign diff_valid = out_valid_q;
  assign diff_sop   = out_sop_q;
  assign diff_eop   = out_eop_q;
  assign diff_data  = out_dif_q;
  assign ovf_sticky = ovf_q;

endmodule

// File: tb/tb_phase_cal_array.sv
// Directed bench for phase_cal_array, NCH=2 default build.
// Inputs change and outputs are sampled on the falling edge.
module tb_phase_cal_array;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_sop;
  logic        in_eop;
  logic [31:0] in_data;
  logic [63:0] coef;
  logic [1:0]  ch_mask;
  logic        ovf_clr;
  logic        sum_valid, sum_sop, sum_eop;
  logic [31:0] sum_data;
  logic        diff_valid, diff_sop, diff_eop;
  logic [31:0] diff_data;
  logic        ovf_sticky;

  int n_cmp = 0;
  int n_err = 0;

  always #5 sys_clk = ~sys_clk;

  phase_cal_array dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_sop     (in_sop),
    .in_eop     (in_eop),
    .in_data    (in_data),
    .coef       (coef),
    .ch_mask    (ch_mask),
    .ovf_clr    (ovf_clr),
    .sum_valid  (sum_valid),
    .sum_sop    (sum_sop),
    .sum_eop    (sum_eop),
    .sum_data   (sum_data),
    .diff_valid (diff_valid),
    .diff_sop   (diff_sop),
    .diff_eop   (diff_eop),
    .diff_data  (diff_data),
    .ovf_sticky (ovf_sticky)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] iq(
    input logic signed [15:0] i,
    input logic signed [15:0] q
  );
    return {q, i};
  endfunction

  function automatic logic [63:0] mk(
    input logic signed [15:0] i0,
    input logic signed [15:0] q0,
    input logic signed [15:0] i1,
    input logic signed [15:0] q1
  );
    return {q1, i1, q0, i0};
  endfunction

  // one sample in, return on the falling edge where it must appear
  task automatic xfer(
    input logic               sop,
    input logic               eop,
    input logic signed [15:0] a,
    input logic signed [15:0] b
  );
    @(negedge sys_clk);
    in_valid = 1'b1;
    in_sop   = sop;
    in_eop   = eop;
    in_data  = {b, a};
    @(negedge sys_clk);
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    repeat (4) @(negedge sys_clk);
  endtask

  logic               ev [16];
  logic               es [16];
  logic               ee [16];
  logic signed [15:0] ex [16];
  logic [31:0]        hold;

  localparam logic [63:0] UNITY = 64'h0000_4000_0000_4000;

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    in_data  = '0;
    coef     = UNITY;
    ch_mask  = 2'b11;
    ovf_clr  = 1'b0;
    hold     = '0;
    repeat (2) @(negedge sys_clk);
    check("rst_valid", 32'(sum_valid), 32'd0);
    check("rst_sum", sum_data, 32'd0);
    check("rst_diff", diff_data, 32'd0);
    check("rst_ovf", 32'(ovf_sticky), 32'd0);
    rst_n = 1'b1;

    // unity shadow without any sop
    xfer(1'b0, 1'b0, 16'sd1000, 16'sd200);
    check("u_valid", 32'(sum_valid), 32'd1);
    check("u_dvalid", 32'(diff_valid), 32'd1);
    check("u_sop", 32'(sum_sop), 32'd0);
    check("u_sum", sum_data, iq(16'sd1200, 16'sd0));
    check("u_diff", diff_data, iq(16'sd800, 16'sd0));
    @(negedge sys_clk);
    check("u_pulse", 32'(sum_valid), 32'd0);
    check("u_hold", sum_data, iq(16'sd1200, 16'sd0));

    // coefficients latch only at sop
    coef = UNITY;
    xfer(1'b1, 1'b0, 16'sd1000, 16'sd0);
    check("c_first", sum_data, iq(16'sd1000, 16'sd0));
    coef = mk(16'sd0, 16'sd16384, 16'sd16384, 16'sd0);
    xfer(1'b0, 1'b1, 16'sd1000, 16'sd0);
    check("c_mid", sum_data, iq(16'sd1000, 16'sd0));
    xfer(1'b1, 1'b1, 16'sd1000, 16'sd0);
    check("c_rot_sum", sum_data, iq(16'sd0, 16'sd1000));
    check("c_rot_diff", diff_data, iq(16'sd0, 16'sd1000));
    check("c_rot_sop", 32'(sum_sop), 32'd1);
    check("c_rot_eop", 32'(sum_eop), 32'd1);
    coef = UNITY;
    xfer(1'b1, 1'b1, 16'sd1000, 16'sd0);
    check("c_back", sum_data, iq(16'sd1000, 16'sd0));

    // half gain on ch0, ch1 masked
    coef    = mk(16'sd8192, 16'sd0, 16'sd16384, 16'sd0);
    ch_mask = 2'b01;
    xfer(1'b1, 1'b0, 16'sd3, 16'sd5000);
    check("r_pos_sum", sum_data, iq(16'sd2, 16'sd0));
    check("r_pos_diff", diff_data, iq(16'sd2, 16'sd0));
    xfer(1'b0, 1'b1, -16'sd3, 16'sd5000);
    check("r_neg_sum", sum_data, iq(-16'sd1, 16'sd0));
    check("r_neg_diff", diff_data, iq(-16'sd1, 16'sd0));

    // saturation and sticky overflow
    coef    = UNITY;
    ch_mask = 2'b11;
    xfer(1'b1, 1'b1, 16'sd32767, 16'sd32767);
    check("s_sum", sum_data, iq(16'sd32767, 16'sd0));
    check("s_diff", diff_data, iq(16'sd0, 16'sd0));
    check("s_ovf", 32'(ovf_sticky), 32'd1);
    xfer(1'b1, 1'b1, -16'sd32768, -16'sd32768);
    check("s_neg", sum_data, iq(-16'sd32768, 16'sd0));
    xfer(1'b1, 1'b1, 16'sd32767, -16'sd32768);
    check("s_dsum", sum_data, iq(-16'sd1, 16'sd0));
    check("s_dmax", diff_data, iq(16'sd32767, 16'sd0));
    ovf_clr = 1'b1;
    @(negedge sys_clk);
    ovf_clr = 1'b0;
    check("s_clr", 32'(ovf_sticky), 32'd0);
    xfer(1'b1, 1'b1, 16'sd100, 16'sd100);
    check("s_noclip", 32'(ovf_sticky), 32'd0);
    check("s_small", sum_data, iq(16'sd200, 16'sd0));
    @(negedge sys_clk);
    in_valid = 1'b1;
    in_sop   = 1'b1;
    in_eop   = 1'b1;
    in_data  = {16'sd32767, 16'sd32767};
    @(negedge sys_clk);
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    repeat (3) @(negedge sys_clk);
    ovf_clr = 1'b1;
    @(negedge sys_clk);
    ovf_clr = 1'b0;
    check("s_setwins", 32'(ovf_sticky), 32'd1);

    // 10-slot frame, gaps at slots 3 and 6, stray sop in gap
    for (int c = 0; c < 16; c++) begin
      ev[c] = (c < 10) && (c != 3) && (c != 6);
      es[c] = (c == 0) || (c == 3);
      ee[c] = (c == 9);
      ex[c] = ev[c] ? 16'(100 * (c + 1)) : 16'sd9999;
    end
    for (int c = 0; c < 16; c++) begin
      @(negedge sys_clk);
      if (c >= 5) begin
        check("f_valid", 32'(sum_valid), 32'(ev[c-5]));
        check("f_sop", 32'(sum_sop), 32'(es[c-5] & ev[c-5]));
        check("f_eop", 32'(sum_eop), 32'(ee[c-5] & ev[c-5]));
        check("f_dvalid", 32'(diff_valid), 32'(ev[c-5]));
        if (ev[c-5]) hold = iq(ex[c-5] + 16'sd7, 16'sd0);
        if (c - 5 < 10) check("f_data", sum_data, hold);
      end
      in_valid = ev[c];
      in_sop   = es[c];
      in_eop   = ee[c];
      in_data  = {16'sd7, ex[c]};
    end
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;

    // reset in mid-frame with a non-unity shadow loaded
    coef = mk(16'sd8192, 16'sd0, 16'sd8192, 16'sd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge sys_clk);
      in_valid = 1'b1;
      in_sop   = (c == 0);
      in_eop   = 1'b0;
      in_data  = {16'sd0, 16'sd1000};
    end
    @(negedge sys_clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    #1;
    check("x_valid", 32'(sum_valid), 32'd0);
    check("x_sum", sum_data, 32'd0);
    check("x_ovf", 32'(ovf_sticky), 32'd0);
    repeat (2) @(negedge sys_clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge sys_clk);
      check("x_novalid", 32'(sum_valid), 32'd0);
      check("x_zero", sum_data, 32'd0);
    end
    xfer(1'b0, 1'b1, 16'sd1000, 16'sd0);
    check("x_unity", sum_data, iq(16'sd1000, 16'sd0));
    check("x_uvalid", 32'(sum_valid), 32'd1);
    xfer(1'b1, 1'b1, 16'sd1000, 16'sd0);
    check("x_half", sum_data, iq(16'sd500, 16'sd0));
    check("x_hdiff", diff_data, iq(16'sd500, 16'sd0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
